// File: rtl/dcache_refill.sv
// dcache_refill: direct-mapped, write-through, no-write-allocate data cache
// for the MEMORY stage. Misses refill a whole line word by word from a slow
// main memory; stores always go to memory and update the line only on a hit.
module dcache_refill #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        readMem,
    input  logic        writeMem,
    output logic        stopCPU,
    output logic [31:0] data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    // Tag is everything above index and word offset (bits [1:0] are byte bits).
    localparam int TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 2 ** INDEX_BITS;
    localparam int WORDS    = 2 ** OFFSET_BITS;

    // Memory handshake: mem_req rises with the address/data already stable and
    // stays high until a one-cycle mem_ready completes the word; mem_ready
    // seen while mem_req is low is ignored.
    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [LINES-1:0]         r_valid;
    logic [TAG_BITS-1:0]      r_tag   [LINES];
    logic [31:0]              r_words [LINES][WORDS];
    logic [OFFSET_BITS-1:0]   r_cnt;
    logic                     r_mem_req;
    logic                     r_mem_we;
    logic [31:0]              r_wr_addr;
    logic [31:0]              r_wdata;

    logic [TAG_BITS-1:0]      w_tag;
    logic [INDEX_BITS-1:0]    w_index;
    logic [OFFSET_BITS-1:0]   w_offset;
    logic                     w_hit;
    logic                     w_ack;
    logic                     w_last;

    assign w_tag    = address[31 -: TAG_BITS];
    assign w_index  = address[31-TAG_BITS -: INDEX_BITS];
    assign w_offset = address[2 +: OFFSET_BITS];
    assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_ack    = mem_ready && r_mem_req;
    assign w_last   = &r_cnt;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_wdata;
    // During a refill the address walks the line; otherwise it is the latched store address.
    assign mem_addr  = (r_state == S_REFILL) ? {w_tag, w_index, r_cnt, 2'b00} : r_wr_addr;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state, stall and load-data decode.
    always_comb begin
        w_next  = r_state;
        stopCPU = 1'b0;
        data    = '0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (writeMem) begin
                        stopCPU = 1'b1;
                        w_next  = S_WRITE;
                    end else if (readMem) begin
                        if (w_hit) begin
                            data = r_words[w_index][w_offset];
                        end else begin
                            stopCPU = 1'b1;
                            w_next  = S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    stopCPU = 1'b1;
                    if (w_ack && w_last) w_next = S_IDLE;
                end
                S_WRITE: begin
                    // Releasing the stall on the ack cycle lets the pipeline advance exactly once.
                    stopCPU = !w_ack;
                    if (w_ack) w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Memory request, refill counter, tags and valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= '0;
            r_cnt     <= '0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_wr_addr <= '0;
            r_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (writeMem) begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b1;
                        r_wr_addr <= address & 32'hFFFF_FFFC;
                        r_wdata   <= writeData;
                    end else if (readMem && !w_hit) begin
                        // Invalidate up front so an abandoned refill never leaves a stale line valid.
                        r_valid[w_index] <= 1'b0;
                        r_mem_req        <= 1'b1;
                        r_mem_we         <= 1'b0;
                        r_cnt            <= '0;
                    end
                end
                S_REFILL: begin
                    if (w_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_tag[w_index]   <= w_tag;
                            r_valid[w_index] <= 1'b1;
                            r_mem_req        <= 1'b0;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line data: refill words arrive in order; store hits update the word in place.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_REFILL && w_ack)
                r_words[w_index][r_cnt] <= mem_rdata;
            else if (r_state == S_WRITE && w_ack && w_hit)
                r_words[w_index][w_offset] <= writeData;
        end
    end

endmodule

// File: tb/tb_dcache_refill.sv
// Bench for dcache_refill: a latency-programmable word memory, a line-level
// reference model of the cache contents, and a scoreboard fed at issue time
// and drained by a monitor that watches the DUT outputs.
module tb_dcache_refill;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, writeData;
  logic        readMem, writeMem;
  logic        stopCPU;
  logic [31:0] data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic [31:0] exp_q[$];
  txn_t        mem_exp_q[$];
  logic [31:0] mem_store [logic [31:0]];
  logic [23:0] m_tag [16];
  logic        m_valid [16];
  int          lat = 1;
  int          passed = 0;
  int          total = 0;

  dcache_refill dut (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .readMem(readMem), .writeMem(writeMem), .stopCPU(stopCPU), .data(data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  task automatic model_invalidate();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // main memory: mem_ready pulses on the lat-th cycle of each requested word
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (rst || !mem_req) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          mem_ready = 1'b1;
          if (mem_we) mem_store[mem_addr] = mem_wdata;
          else        mem_rdata = mem_rd(mem_addr);
        end
      end
    end
  end

  // monitor: memory transactions and load data against the expected queues
  always @(negedge clk) begin : mon
    txn_t        et;
    logic [31:0] ed;
    if (!rst) begin
      if (mem_req && mem_ready) begin
        total++;
        if (mem_exp_q.size() == 0) begin
          $display("FAIL mem_txn: unexpected we=%0b addr=%h wdata=%h, none expected", mem_we, mem_addr, mem_wdata);
        end else begin
          et = mem_exp_q.pop_front();
          if (mem_we !== et.we || mem_addr !== et.addr || (et.we && mem_wdata !== et.wdata))
            $display("FAIL mem_txn: got we=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, et.we, et.addr, et.wdata);
          else
            passed++;
        end
      end
      if (readMem && !writeMem && !stopCPU) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL load_data: unexpected completion data=%h addr=%h", data, address);
        end else begin
          ed = exp_q.pop_front();
          if (data !== ed) $display("FAIL load_data: addr=%h got %h expected %h", address, data, ed);
          else passed++;
        end
      end else if (!(readMem && !stopCPU)) begin
        total++;
        if (data !== 32'h0) $display("FAIL data_idle: got %h expected 00000000", data);
        else passed++;
      end
    end
  end

  // driver: issue one access, push expectations, hold it until the stall lifts
  task automatic access(input logic is_rd, input logic is_wr, input logic [31:0] a,
                        input logic [31:0] wd, input int l);
    logic [23:0] tg;
    logic [3:0]  ix;
    logic [31:0] wa;
    int          exp_stall;
    int          stall;
    bit          done;
    tg = a[31:8];
    ix = a[7:4];
    wa = {a[31:2], 2'b00};
    @(posedge clk); #2;
    lat = l;
    address = a; writeData = wd; readMem = is_rd; writeMem = is_wr;
    if (is_wr) begin
      exp_stall = l;
      mem_exp_q.push_back(txn_t'{we: 1'b1, addr: wa, wdata: wd});
    end else begin
      exp_q.push_back(mem_rd(wa));
      if (m_valid[ix] && m_tag[ix] == tg) begin
        exp_stall = 0;
      end else begin
        exp_stall = 1 + 4 * l;
        for (int w = 0; w < 4; w++)
          mem_exp_q.push_back(txn_t'{we: 1'b0, addr: {a[31:4], 4'h0} + 32'(4 * w), wdata: 32'h0});
        m_tag[ix] = tg;
        m_valid[ix] = 1'b1;
      end
    end
    done = 0;
    stall = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!stopCPU) done = 1;
      else stall++;
    end
    total++;
    if (done && stall == exp_stall) passed++;
    else $display("FAIL stall: addr=%h rd=%0b wr=%0b got %0d cycles (done=%0b) expected %0d",
                  a, is_rd, is_wr, stall, done, exp_stall);
    @(posedge clk); #2;
    readMem = 1'b0; writeMem = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) $display("FAIL %s: got %0b expected %0b", name, got, want);
    else passed++;
  endtask

  initial begin
    int nr;
    logic [31:0] a;
    int kind;
    rst = 1'b1;
    address = 32'h100; writeData = '0; readMem = 1'b1; writeMem = 1'b0;
    model_invalidate();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("rst_stopCPU", stopCPU, 1'b0);
    check_bit("rst_mem_req", mem_req, 1'b0);
    check_bit("rst_mem_we", mem_we, 1'b0);
    total++;
    if (data !== 32'h0) $display("FAIL rst_data: got %h expected 00000000", data); else passed++;
    @(posedge clk); #2;
    readMem = 1'b0;
    rst = 1'b0;

    // directed cases
    access(1, 0, 32'h100, 32'h0, 3);           // cold miss, 13 stall cycles
    access(1, 0, 32'h10C, 32'h0, 3);           // hit, no stall
    access(0, 1, 32'h104, 32'hDEAD_BEEF, 2);   // store hit
    access(1, 0, 32'h104, 32'h0, 2);           // reads back DEADBEEF
    access(0, 1, 32'h300, 32'h1234_5678, 3);   // store miss, no allocate
    access(1, 0, 32'h300, 32'h0, 1);           // misses and refills
    access(1, 0, 32'h100, 32'h0, 2);
    access(1, 0, 32'h200, 32'h0, 2);           // conflict on index 0
    access(1, 0, 32'h100, 32'h0, 1);           // misses again
    access(1, 1, 32'h500, 32'hCAFE_F00D, 2);   // both high: store only
    access(1, 0, 32'h500, 32'h0, 1);           // not allocated by the store

    // reset after the second refill word
    @(posedge clk); #2;
    lat = 2;
    address = 32'h100; readMem = 1'b1;
    mem_exp_q.push_back(txn_t'{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    mem_exp_q.push_back(txn_t'{we: 1'b0, addr: 32'h104, wdata: 32'h0});
    nr = 0;
    for (int k = 0; k < 100 && nr < 2; k++) begin
      @(negedge clk);
      if (mem_req && mem_ready) nr++;
    end
    total++;
    if (nr == 2) passed++; else $display("FAIL rst_refill_words: got %0d words expected 2", nr);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    check_bit("midrst_stopCPU", stopCPU, 1'b0);
    @(posedge clk); #2;
    readMem = 1'b0;
    @(negedge clk);
    check_bit("midrst_mem_req", mem_req, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    mem_exp_q.delete();
    exp_q.delete();
    model_invalidate();
    access(1, 0, 32'h100, 32'h0, 2);           // full refill from word 0

    // randomized traffic over a few lines with tag conflicts
    for (int n = 0; n < 60; n++) begin
      a = {24'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      kind = $urandom_range(0, 9);
      if (kind < 6)      access(1, 0, a, 32'h0, $urandom_range(1, 4));
      else if (kind < 9) access(0, 1, a, $urandom, $urandom_range(1, 4));
      else               access(1, 1, a, $urandom, $urandom_range(1, 4));
    end

    repeat (5) @(posedge clk);
    total++;
    if (exp_q.size() == 0 && mem_exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d loads and %0d memory transactions left, expected 0 and 0",
                  exp_q.size(), mem_exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
